// File: rtl/alu_wb_pkg.sv
// Shared core package for the ALU write-back block.
// Holds the datapath and commit sizing constants, the per-source FIFO entry
// layout and a small pointer-wrap helper used by the FIFO.
package alu_wb_pkg;

    localparam int unsigned RV       = 64;  // datapath width
    localparam int unsigned NCOMMIT  = 32;  // commit registers
    localparam int unsigned LNCOMMIT = 5;   // commit index bits
    localparam int unsigned DEPTH    = 4;   // entries per source FIFO

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [RV-1:0]       data;
        logic [LNCOMMIT-1:0] rd;
        logic                live;
    } fifo_entry_t;

    // Advance a FIFO pointer, wrapping modulo DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Per-ALU result FIFO for the write-back block.
// Ports:
//   clk_i, rst_ni   clock and synchronous active-low reset
//   push_i          store push_entry_i this edge (live bit already kill-qualified)
//   grant_i         head has been granted the commit write port this cycle
//   kill_i          commit entries flushed this cycle; matching stored entries go dead
//   head_live_o     FIFO non-empty and its head is live
//   head_data_o/head_rd_o  head contents
//   count_o         registered occupancy
//   drop_o          push arrived at a full FIFO with no pop this cycle
module alu_wb_fifo
    import alu_wb_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  fifo_entry_t         push_entry_i,
    input  logic                grant_i,
    input  logic [NCOMMIT-1:0]  kill_i,
    output logic                head_live_o,
    output logic [RV-1:0]       head_data_o,
    output logic [LNCOMMIT-1:0] head_rd_o,
    output logic [CNTW-1:0]     count_o,
    output logic                drop_o
);

    fifo_entry_t     mem_q [DEPTH];
    fifo_entry_t     mem_d [DEPTH];
    logic [PTRW-1:0] wptr_q, wptr_d;
    logic [PTRW-1:0] rptr_q, rptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            non_empty, full, pop, push_ok;

    always_comb begin
        mem_d = mem_q;
        // Kill every slot by rd; stale slots outside the occupied range are harmless.
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_i[mem_q[i].rd]) begin
                mem_d[i].live = 1'b0;
            end
        end

        non_empty = (count_q != '0);
        full      = (count_q == CNTW'(DEPTH));
        // Dead heads drain on their own, regardless of grant or stall.
        pop       = non_empty && (!mem_q[rptr_q].live || grant_i);
        push_ok   = push_i && (!full || pop);

        // When full and popping, wptr == rptr: the new entry reuses the freed slot.
        if (push_ok) begin
            mem_d[wptr_q] = push_entry_i;
        end

        wptr_d  = push_ok ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = pop ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign head_live_o = non_empty && mem_q[rptr_q].live;
    assign head_data_o = mem_q[rptr_q].data;
    assign head_rd_o   = mem_q[rptr_q].rd;
    assign count_o     = count_q;
    assign drop_o      = push_i && full && !pop;

endmodule

// File: rtl/alu_wb.sv
// ALU result write-back arbiter.
// Buffers results from NALU ALUs in per-source FIFOs and writes them to the
// commit register file one per cycle, round-robin between live FIFO heads.
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   alu_result/alu_rd/alu_makes_rd  per-ALU result, destination and valid
//   commit_kill     commit entries flushed this cycle
//   wr_stall        commit write port taken by a higher-priority writer
//   wr_enable/wr_addr/wr_data/wr_src  commit write port and one-hot granted source
//   alu_stall       per-ALU issue back-pressure
//   overflow        sticky: a result was dropped at a full FIFO
module alu_wb
    import alu_wb_pkg::fifo_entry_t;
    import alu_wb_pkg::CNTW;
#(
    parameter int unsigned RV       = 64,
    parameter int unsigned NCOMMIT  = 32,
    parameter int unsigned LNCOMMIT = 5,
    parameter int unsigned NALU     = 2,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NALU*RV-1:0]       alu_result,
    input  logic [NALU*LNCOMMIT-1:0] alu_rd,
    input  logic [NALU-1:0]          alu_makes_rd,
    input  logic [NCOMMIT-1:0]       commit_kill,
    input  logic                     wr_stall,
    output logic                     wr_enable,
    output logic [LNCOMMIT-1:0]      wr_addr,
    output logic [RV-1:0]            wr_data,
    output logic [NALU-1:0]          wr_src,
    output logic [NALU-1:0]          alu_stall,
    output logic                     overflow
);

    localparam int unsigned RRW = (NALU > 1) ? $clog2(NALU) : 1;

    logic [NALU-1:0]     head_live;
    logic [NALU-1:0]     drop;
    logic [RV-1:0]       head_data [NALU];
    logic [LNCOMMIT-1:0] head_rd   [NALU];
    logic [CNTW-1:0]     count     [NALU];

    logic [RRW-1:0] rr_q, rr_d;
    logic [RRW-1:0] gnt_idx, cand;
    logic           gnt_found;
    logic           overflow_q, overflow_d;

    for (genvar i = 0; i < NALU; i++) begin : g_src
        logic [LNCOMMIT-1:0] rd;
        fifo_entry_t         push_entry;

        assign rd = alu_rd[i*LNCOMMIT +: LNCOMMIT];
        // A result whose rd is flushed on its push edge is stored already dead.
        assign push_entry = '{data: alu_result[i*RV +: RV], rd: rd, live: !commit_kill[rd]};

        alu_wb_fifo u_fifo (
            .clk_i        (clk),
            .rst_ni       (reset),
            .push_i       (alu_makes_rd[i]),
            .push_entry_i (push_entry),
            .grant_i      (wr_src[i]),
            .kill_i       (commit_kill),
            .head_live_o  (head_live[i]),
            .head_data_o  (head_data[i]),
            .head_rd_o    (head_rd[i]),
            .count_o      (count[i]),
            .drop_o       (drop[i])
        );

        // Two results can already be in flight in the ALU when this asserts.
        assign alu_stall[i] = (count[i] >= CNTW'(DEPTH - 2));
    end

    // Round-robin: scan live heads starting at the preferred source.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_q;
        cand      = '0;
        for (int k = 0; k < NALU; k++) begin
            cand = RRW'((32'(rr_q) + 32'(k)) % NALU);
            if (!gnt_found && head_live[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end

        wr_enable = !wr_stall && gnt_found;
        wr_src    = wr_enable ? (NALU'(1) << gnt_idx) : '0;
        wr_addr   = head_rd[gnt_idx];
        wr_data   = head_data[gnt_idx];

        rr_d = rr_q;
        if (wr_enable) begin
            rr_d = (gnt_idx == RRW'(NALU - 1)) ? '0 : gnt_idx + 1'b1;
        end

        overflow_d = overflow_q | (|drop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_wb.sv
// Self-checking bench for alu_wb: table-driven vectors, directed corner
// sequences and a randomized run, all compared against a queue-level model.
module tb_alu_wb;

    localparam int NALU  = 2;
    localparam int DEPTH = 4;
    localparam int RV    = 64;
    localparam int LN    = 5;
    localparam int NC    = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [NALU*RV-1:0]   alu_result;
    logic [NALU*LN-1:0]   alu_rd;
    logic [NALU-1:0]      alu_makes_rd;
    logic [NC-1:0]        commit_kill;
    logic                 wr_stall;
    logic                 wr_enable;
    logic [LN-1:0]        wr_addr;
    logic [RV-1:0]        wr_data;
    logic [NALU-1:0]      wr_src;
    logic [NALU-1:0]      alu_stall;
    logic                 overflow;

    alu_wb #(
        .RV       (RV),
        .NCOMMIT  (NC),
        .LNCOMMIT (LN),
        .NALU     (NALU),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .alu_result   (alu_result),
        .alu_rd       (alu_rd),
        .alu_makes_rd (alu_makes_rd),
        .commit_kill  (commit_kill),
        .wr_stall     (wr_stall),
        .wr_enable    (wr_enable),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_src       (wr_src),
        .alu_stall    (alu_stall),
        .overflow     (overflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: each source is an ordered list, index 0 is the oldest entry.
    typedef struct {
        logic [RV-1:0] data;
        logic [LN-1:0] rd;
        bit            live;
    } ment_t;

    ment_t mq [NALU][DEPTH];
    int    msize [NALU];
    int    mrr;
    bit    movf;
    bit    exp_en;
    int    exp_g;

    typedef struct {
        bit          rst;
        logic [1:0]  mk;
        logic [63:0] d0, d1;
        logic [4:0]  r0, r1;
        logic        en;
        logic [1:0]  src;
        logic [4:0]  addr;
        logic [63:0] data;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_grant();
        exp_en = 1'b0;
        exp_g  = 0;
        if (!wr_stall) begin
            for (int k = 0; k < NALU; k++) begin
                int s;
                s = (mrr + k) % NALU;
                if (!exp_en && msize[s] > 0 && mq[s][0].live) begin
                    exp_en = 1'b1;
                    exp_g  = s;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [NALU-1:0] es;
        model_grant();
        chk("wr_enable", 64'(wr_enable), 64'(exp_en));
        chk("wr_src", 64'(wr_src), exp_en ? (64'd1 << exp_g) : 64'd0);
        if (exp_en) begin
            chk("wr_addr", 64'(wr_addr), 64'(mq[exp_g][0].rd));
            chk("wr_data", wr_data, mq[exp_g][0].data);
        end
        for (int i = 0; i < NALU; i++) es[i] = (msize[i] >= DEPTH - 2);
        chk("alu_stall", 64'(alu_stall), 64'(es));
        chk("overflow", 64'(overflow), 64'(movf));
    endtask

    task automatic model_update();
        bit popped [NALU];
        int old [NALU];
        logic [LN-1:0] r;
        if (!rst_n) begin
            for (int i = 0; i < NALU; i++) msize[i] = 0;
            mrr  = 0;
            movf = 1'b0;
            return;
        end
        model_grant();
        for (int i = 0; i < NALU; i++) begin
            old[i]    = msize[i];
            popped[i] = 1'b0;
            if (msize[i] > 0 && (!mq[i][0].live || (exp_en && exp_g == i))) begin
                for (int j = 0; j < DEPTH - 1; j++) mq[i][j] = mq[i][j+1];
                msize[i]--;
                popped[i] = 1'b1;
            end
        end
        for (int i = 0; i < NALU; i++)
            for (int j = 0; j < msize[i]; j++)
                if (commit_kill[mq[i][j].rd]) mq[i][j].live = 1'b0;
        for (int i = 0; i < NALU; i++) begin
            if (alu_makes_rd[i]) begin
                if (old[i] == DEPTH && !popped[i]) begin
                    movf = 1'b1;
                end else begin
                    r = alu_rd[i*LN +: LN];
                    mq[i][msize[i]] = '{data: alu_result[i*RV +: RV], rd: r, live: !commit_kill[r]};
                    msize[i]++;
                end
            end
        end
        if (exp_en) mrr = (exp_g + 1) % NALU;
    endtask

    task automatic drive(input bit rst, input logic [1:0] mk, input logic [63:0] d0,
                         input logic [63:0] d1, input logic [4:0] r0, input logic [4:0] r1,
                         input bit st, input logic [31:0] kl);
        rst_n        = rst;
        alu_makes_rd = mk;
        alu_result   = {d1, d0};
        alu_rd       = {r1, r0};
        wr_stall     = st;
        commit_kill  = kl;
    endtask

    // Inputs go in just after a rising edge; outputs are sampled at the falling edge.
    task automatic begin_cyc(input bit rst, input logic [1:0] mk, input logic [63:0] d0,
                             input logic [63:0] d1, input logic [4:0] r0, input logic [4:0] r1,
                             input bit st, input logic [31:0] kl);
        drive(rst, mk, d0, d1, r0, r1, st, kl);
        #4;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic add(input bit rst, input logic [1:0] mk, input logic [63:0] d0,
                       input logic [4:0] r0, input logic [63:0] d1, input logic [4:0] r1,
                       input logic en, input logic [1:0] src, input logic [4:0] addr,
                       input logic [63:0] data);
        vec_t v;
        v.rst = rst; v.mk = mk; v.d0 = d0; v.d1 = d1; v.r0 = r0; v.r1 = r1;
        v.en = en; v.src = src; v.addr = addr; v.data = data;
        tbl.push_back(v);
    endtask

    initial begin
        logic [31:0] kl;
        logic [1:0]  mk;

        // Power-up reset; DUT state is unknown until this edge.
        drive(1'b0, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        tick();

        begin_cyc(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        chk("reset_en", 64'(wr_enable), 64'd0);
        chk("reset_src", 64'(wr_src), 64'd0);
        chk("reset_stall", 64'(alu_stall), 64'd0);
        chk("reset_ovf", 64'(overflow), 64'd0);
        tick();

        // Single push, then two-source contention.
        add(1, 2'b01, 64'h1234, 5, 0, 0, 0, 2'b00, 0, 0);
        add(1, 2'b00, 0, 0, 0, 0, 1, 2'b01, 5, 64'h1234);
        add(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        add(0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        add(1, 2'b11, 64'h111, 1, 64'h999, 9, 0, 2'b00, 0, 0);
        add(1, 2'b11, 64'h222, 2, 64'hAAA, 10, 1, 2'b01, 1, 64'h111);
        add(1, 2'b11, 64'h333, 3, 64'hBBB, 11, 1, 2'b10, 9, 64'h999);
        add(1, 2'b11, 64'h444, 4, 64'hCCC, 12, 1, 2'b01, 2, 64'h222);
        add(1, 2'b00, 0, 0, 0, 0, 1, 2'b10, 10, 64'hAAA);
        add(1, 2'b00, 0, 0, 0, 0, 1, 2'b01, 3, 64'h333);
        add(1, 2'b00, 0, 0, 0, 0, 1, 2'b10, 11, 64'hBBB);
        add(1, 2'b00, 0, 0, 0, 0, 1, 2'b01, 4, 64'h444);
        add(1, 2'b00, 0, 0, 0, 0, 1, 2'b10, 12, 64'hCCC);
        add(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0);

        foreach (tbl[n]) begin
            begin_cyc(tbl[n].rst, tbl[n].mk, tbl[n].d0, tbl[n].d1, tbl[n].r0, tbl[n].r1,
                      1'b0, '0);
            chk("tbl_en", 64'(wr_enable), 64'(tbl[n].en));
            chk("tbl_src", 64'(wr_src), 64'(tbl[n].src));
            if (tbl[n].en) begin
                chk("tbl_addr", 64'(wr_addr), 64'(tbl[n].addr));
                chk("tbl_data", wr_data, tbl[n].data);
            end
            chk("tbl_ovf", 64'(overflow), 64'd0);
            tick();
        end

        // Stall with back-pressure, then in-order drain.
        begin_cyc(1'b0, 2'b00, '0, '0, '0, '0, 1'b0, '0); tick();
        begin_cyc(1'b1, 2'b01, 64'hA1, '0, 5'd1, '0, 1'b0, '0); tick();
        begin_cyc(1'b1, 2'b01, 64'hA2, '0, 5'd2, '0, 1'b1, '0);
        chk("stall_c1", 64'(alu_stall[0]), 64'd0);
        tick();
        begin_cyc(1'b1, 2'b01, 64'hA3, '0, 5'd3, '0, 1'b1, '0);
        chk("stall_c2", 64'(alu_stall[0]), 64'd1);
        chk("stall_c2_en", 64'(wr_enable), 64'd0);
        tick();
        begin_cyc(1'b1, 2'b00, '0, '0, '0, '0, 1'b1, '0);
        chk("stall_c3", 64'(alu_stall[0]), 64'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            begin_cyc(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0);
            chk("stall_drain_addr", 64'(wr_addr), 64'(k + 1));
            chk("stall_drain_data", wr_data, 64'hA1 + 64'(k));
            tick();
        end
        begin_cyc(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        chk("stall_done_en", 64'(wr_enable), 64'd0);
        tick();

        // Kill of a stalled entry.
        begin_cyc(1'b0, 2'b00, '0, '0, '0, '0, 1'b0, '0); tick();
        begin_cyc(1'b1, 2'b10, '0, 64'h77, '0, 5'd7, 1'b0, '0); tick();
        begin_cyc(1'b1, 2'b00, '0, '0, '0, '0, 1'b1, 32'h80);
        chk("kill_c1_en", 64'(wr_enable), 64'd0);
        tick();
        begin_cyc(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        chk("kill_c2_en", 64'(wr_enable), 64'd0);
        tick();
        begin_cyc(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        chk("kill_c3_en", 64'(wr_enable), 64'd0);
        tick();

        // Overflow: five pushes into a stalled four-entry FIFO.
        begin_cyc(1'b0, 2'b00, '0, '0, '0, '0, 1'b0, '0); tick();
        for (int k = 0; k < 5; k++) begin
            begin_cyc(1'b1, 2'b01, 64'hB0 + 64'(k), '0, 5'(k + 1), '0, 1'b1, '0);
            chk("ovf_pre", 64'(overflow), 64'd0);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            begin_cyc(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0);
            chk("ovf_flag", 64'(overflow), 64'd1);
            chk("ovf_drain_addr", 64'(wr_addr), 64'(k + 1));
            chk("ovf_drain_data", wr_data, 64'hB0 + 64'(k));
            tick();
        end
        begin_cyc(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        chk("ovf_done_en", 64'(wr_enable), 64'd0);
        tick();

        // Reset mid-operation with both FIFOs holding 3 entries and the pointer at source 1.
        for (int k = 0; k < 3; k++) begin
            begin_cyc(1'b1, 2'b11, 64'hD0 + 64'(k), 64'hE0 + 64'(k), 5'(20 + k), 5'(24 + k),
                      1'b1, '0);
            tick();
        end
        begin_cyc(1'b0, 2'b11, 64'hF0, 64'hF1, 5'd28, 5'd29, 1'b0, 32'h1000_0000);
        tick();
        begin_cyc(1'b1, 2'b11, 64'hC0, 64'hC1, 5'd1, 5'd2, 1'b0, '0);
        chk("rst_mid_en", 64'(wr_enable), 64'd0);
        chk("rst_mid_stall", 64'(alu_stall), 64'd0);
        chk("rst_mid_ovf", 64'(overflow), 64'd0);
        tick();
        begin_cyc(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        chk("rst_mid_src0", 64'(wr_src), 64'd1);
        chk("rst_mid_addr0", 64'(wr_addr), 64'd1);
        tick();
        begin_cyc(1'b1, 2'b00, '0, '0, '0, '0, 1'b0, '0);
        chk("rst_mid_src1", 64'(wr_src), 64'd2);
        tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            mk[0] = ($urandom_range(99) < 35);
            mk[1] = ($urandom_range(99) < 35);
            kl    = '0;
            if ($urandom_range(99) < 15) kl[$urandom_range(7)] = 1'b1;
            begin_cyc(($urandom_range(99) != 0), mk, {$urandom, $urandom}, {$urandom, $urandom},
                      5'($urandom_range(7)), 5'($urandom_range(7)),
                      ($urandom_range(99) < 25), kl);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_wb.md
ALU_WB -- requirements
Module: alu_wb

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
  RV 64 datapath width
  NCOMMIT 32 commit registers
  LNCOMMIT 5 commit index bits
  NALU 2 ALU result sources
  DEPTH 4 entries per source FIFO
REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
  clk  input  1  sole clock, rising edge
  reset  input  1  synchronous, active-low (0 = reset)
  alu_result  input  NALU*RV  per-ALU result, source i at [i*RV +: RV]
  alu_rd  input  NALU*LNCOMMIT  per-ALU destination commit index
  alu_makes_rd  input  NALU  per-ALU result valid
  commit_kill  input  NCOMMIT  bit n set = commit entry n flushed this cycle
  wr_stall  input  1  commit write port taken by a higher-priority writer
  wr_enable  output  1  commit register write strobe
  wr_addr  output  LNCOMMIT  commit register write index
  wr_data  output  RV  commit register write data
  wr_src  output  NALU  one-hot granted source
  alu_stall  output  NALU  scheduler must stop issuing to ALU i
  overflow  output  1  sticky protocol error

Function
REQ-003 Each source SHALL have a DEPTH-entry FIFO (data, rd, live bit); alu_makes_rd[i]=1 pushes at the cycle-N edge; earliest wr_enable for that entry is cycle N+1.
REQ-004 wr_enable SHALL be combinational: 1 iff !wr_stall and at least one FIFO head is live; wr_addr/wr_data/wr_src come from the granted head; wr_enable=0 forces wr_src=0.
REQ-005 Arbitration SHALL be round-robin: the pointer names the preferred source; if that head is not live, the other live head is granted; after every grant, the pointer advances to the source after the granted one; no grant, no pointer change.
REQ-006 The granted head SHALL pop at the edge when wr_enable=1; wr_stall=1 pops no live head and holds the pointer.
REQ-007 Kill: at each edge, every stored entry whose rd bit is set in commit_kill SHALL have its live bit cleared; an entry being pushed that edge with its rd killed SHALL be stored dead.
REQ-008 A dead head SHALL pop at the next edge, independent of grant and wr_stall; at most one pop per FIFO per cycle.
REQ-009 Push and pop on the same FIFO in the same cycle SHALL be legal at any occupancy, including full; count remains unchanged.
REQ-010 alu_stall[i] SHALL equal (count_i >= DEPTH-2), from registered count, covering the 2-cycle ALU in-flight window.
REQ-011 A push to a full FIFO with no same-cycle pop SHALL drop the entry and set overflow=1, held until reset.
REQ-012 FIFO pointers SHALL wrap modulo DEPTH; count width is clog2(DEPTH)+1.

Reset
REQ-013 When reset=0 at an edge: all counts and pointers=0, all live bits=0, round-robin pointer=source 0, overflow=0; hence wr_enable=0, wr_src=0, alu_stall=0 in the next cycle.
REQ-014 Reset SHALL override simultaneous pushes, pops and kills; no entry survives it.

Structure
REQ-015 RV, NCOMMIT, LNCOMMIT, DEPTH and the FIFO entry typedef {data, rd, live} SHALL live in the shared core package.
REQ-016 Per-source storage SHALL be one sub-module, alu_wb_fifo, instantiated NALU times; arbitration, kill fan-out and overflow stay in alu_wb.

Verification
REQ-017 Single push: ALU0 result 0x1234, rd 5, cycle 0 -> cycle 1 wr_enable=1, wr_addr=5, wr_data=0x1234, wr_src=01; cycle 2 wr_enable=0.
REQ-018 Contention: both ALUs push in cycles 0-3 (rd 1-4 and 9-12) -> writes alternate 1,9,2,10,3,11,4,12 over cycles 1-8; no overflow.
REQ-019 wr_stall=1 in cycles 1-3 with ALU0 pushing in cycles 0-2 -> alu_stall[0]=1 once count reaches 2; writes resume in cycle 4 in push order.
REQ-020 Kill: ALU1 pushes rd 7 in cycle 0 and wr_stall=1 in cycle 1; commit_kill[7]=1 in cycle 1 -> rd 7 never written; FIFO 1 empty by cycle 3.
REQ-021 Overflow: wr_stall=1 and ALU0 pushes 5 times -> overflow=1 after the 5th push; the first 4 entries are written in order after stall release.
REQ-022 Reset mid-operation: reset=0 for one cycle with both FIFOs holding 3 entries -> next cycle wr_enable=0, alu_stall=00, overflow=0; the pointer prefers source 0.
